// File: rtl/mem_walker_pkg.sv
// ---------------------------------------------------------------------------
// mem_walker_pkg
// Shared types and helpers for the N-dimensional strided address walker.
//   - num_loops_f / num_groups_f : derive loop/group counts from id widths
//   - state_t                    : walker control state {IDLE, RUN}
//   - loop_cfg_t                 : one loop's configuration entry
// The stride/iter field widths here set the stored configuration width.
// The walker's ADDR_STRIDE_W / ITER_W parameters default to these widths.
// ---------------------------------------------------------------------------
package mem_walker_pkg;

    localparam int CFG_STRIDE_W = 16;
    localparam int CFG_ITER_W   = 16;

    function automatic int num_loops_f(input int loop_id_w);
        return 1 << loop_id_w;
    endfunction

    function automatic int num_groups_f(input int group_id_w);
        return 1 << group_id_w;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic signed [CFG_STRIDE_W-1:0] stride;
        logic        [CFG_ITER_W-1:0]   iter;
    } loop_cfg_t;

endpackage

// File: rtl/mem_walker_carry_chain.sv
// ---------------------------------------------------------------------------
// mem_walker_carry_chain
// Purely combinational carry search for the loop nest.
// Ports:
//   cnt        in  per-loop trip counters (index NUM_LOOPS-1 is innermost)
//   iter       in  per-loop trip counts (0 behaves as 1)
//   adv_onehot out the innermost loop that still has iterations left
//   reset_mask out loops inside the advancing loop; they restart at 0
//   last       out no loop can advance, so the current beat is the final one
// ---------------------------------------------------------------------------
module mem_walker_carry_chain #(
    parameter int NUM_LOOPS = 8,
    parameter int ITER_W    = 16
) (
    input  logic [NUM_LOOPS-1:0][ITER_W-1:0] cnt,
    input  logic [NUM_LOOPS-1:0][ITER_W-1:0] iter,
    output logic [NUM_LOOPS-1:0]             adv_onehot,
    output logic [NUM_LOOPS-1:0]             reset_mask,
    output logic                             last
);

    logic [NUM_LOOPS-1:0] full;

    // A loop is full when its counter sits on the final iteration.
    always_comb begin
        full = '0;
        for (int l = 0; l < NUM_LOOPS; l++) begin
            if (iter[l] == '0) begin
                full[l] = (cnt[l] == '0);
            end else begin
                full[l] = (cnt[l] == (iter[l] - ITER_W'(1)));
            end
        end
    end

    // Scan from innermost outward: the first non-full loop advances.
    always_comb begin
        logic inner_full;
        adv_onehot = '0;
        inner_full = 1'b1;
        for (int l = NUM_LOOPS - 1; l >= 0; l--) begin
            adv_onehot[l] = inner_full && !full[l];
            inner_full    = inner_full && full[l];
        end
    end

    // Every loop strictly inside the advancing loop restarts.
    always_comb begin
        logic outer_adv;
        reset_mask = '0;
        outer_adv  = 1'b0;
        for (int l = 0; l < NUM_LOOPS; l++) begin
            reset_mask[l] = outer_adv;
            outer_adv     = outer_adv | adv_onehot[l];
        end
    end

    assign last = ~|adv_onehot;

endmodule

// File: rtl/mem_walker_nd.sv
// ---------------------------------------------------------------------------
// mem_walker_nd
// N-dimensional strided address walker. The decoder writes per-group loop
// configuration (signed stride, trip count); a start launches a walk over the
// selected group and one address is offered per cycle on a valid/ready port.
// Ports:
//   clk, reset                  single clock, synchronous active-high reset
//   cfg_v/cfg_group_id/cfg_loop_id/cfg_stride/cfg_iter
//                               configuration write (dropped for running group)
//   start/start_group_id/base_addr
//                               walk launch, accepted only in IDLE
//   addr_out/addr_out_valid/addr_out_ready
//                               address beat handshake
//   busy                        walk in progress
//   done                        one-cycle pulse after the final accepted beat
// Optional feature macro: MEM_WALKER_WRAP_EN adds wrap_base/wrap_size inputs
// (sampled on start) that fold every updated address into a circular window.
// ---------------------------------------------------------------------------
module mem_walker_nd
    import mem_walker_pkg::*;
#(
    parameter int ADDR_WIDTH    = 48,
    parameter int ADDR_STRIDE_W = CFG_STRIDE_W,
    parameter int ITER_W        = CFG_ITER_W,
    parameter int LOOP_ID_W     = 3,
    parameter int GROUP_ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_v,
    input  logic [GROUP_ID_W-1:0]    cfg_group_id,
    input  logic [LOOP_ID_W-1:0]     cfg_loop_id,
    input  logic [ADDR_STRIDE_W-1:0] cfg_stride,
    input  logic [ITER_W-1:0]        cfg_iter,
    input  logic                     start,
    input  logic [GROUP_ID_W-1:0]    start_group_id,
    input  logic [ADDR_WIDTH-1:0]    base_addr,
`ifdef MEM_WALKER_WRAP_EN
    input  logic [ADDR_WIDTH-1:0]    wrap_base,
    input  logic [ADDR_WIDTH-1:0]    wrap_size,
`endif
    output logic [ADDR_WIDTH-1:0]    addr_out,
    output logic                     addr_out_valid,
    input  logic                     addr_out_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int NUM_LOOPS  = num_loops_f(LOOP_ID_W);
    localparam int NUM_GROUPS = num_groups_f(GROUP_ID_W);

    state_t                              state_q, state_d;
    logic [GROUP_ID_W-1:0]               grp_q, grp_d;
    loop_cfg_t                           cfg_q [NUM_GROUPS][NUM_LOOPS];
    loop_cfg_t                           cfg_d [NUM_GROUPS][NUM_LOOPS];
    loop_cfg_t                           run_cfg_q [NUM_LOOPS];
    loop_cfg_t                           run_cfg_d [NUM_LOOPS];
    logic [NUM_LOOPS-1:0][ITER_W-1:0]     cnt_q, cnt_d;
    logic [NUM_LOOPS-1:0][ADDR_WIDTH-1:0] acc_q, acc_d;
    logic                                done_q, done_d;
`ifdef MEM_WALKER_WRAP_EN
    logic [ADDR_WIDTH-1:0]               wrap_base_q, wrap_base_d;
    logic [ADDR_WIDTH-1:0]               wrap_size_q, wrap_size_d;
`endif

    logic [NUM_LOOPS-1:0][ITER_W-1:0]     run_iter;
    logic [NUM_LOOPS-1:0]                adv;
    logic [NUM_LOOPS-1:0]                inner_rst;
    logic                                last;
    logic                                start_go;
    logic                                beat_fire;
    logic [ADDR_WIDTH-1:0]               step_addr;

    function automatic logic [ADDR_WIDTH-1:0] sext_stride(
        input logic signed [CFG_STRIDE_W-1:0] s
    );
        return {{(ADDR_WIDTH-CFG_STRIDE_W){s[CFG_STRIDE_W-1]}}, s};
    endfunction

`ifdef MEM_WALKER_WRAP_EN
    // Fold an updated address back into [wrap_base, wrap_base+wrap_size).
    // The direction of the step decides which edge can be crossed.
    function automatic logic [ADDR_WIDTH-1:0] wrap_addr(
        input logic [ADDR_WIDTH-1:0] a,
        input logic                  neg
    );
        logic [ADDR_WIDTH-1:0] r;
        r = a;
        if (wrap_size_q != '0) begin
            if (!neg && (a >= wrap_base_q + wrap_size_q)) begin
                r = a - wrap_size_q;
            end else if (neg && (a < wrap_base_q)) begin
                r = a + wrap_size_q;
            end
        end
        return r;
    endfunction
`endif

    assign start_go  = (state_q == IDLE) && start;
    assign beat_fire = (state_q == RUN) && addr_out_ready;

    always_comb begin
        for (int l = 0; l < NUM_LOOPS; l++) begin
            run_iter[l] = ITER_W'(run_cfg_q[l].iter);
        end
    end

    mem_walker_carry_chain #(
        .NUM_LOOPS (NUM_LOOPS),
        .ITER_W    (ITER_W)
    ) u_carry (
        .cnt        (cnt_q),
        .iter       (run_iter),
        .adv_onehot (adv),
        .reset_mask (inner_rst),
        .last       (last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start)              state_d = RUN;
            RUN:  if (beat_fire && last)  state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        addr_out_valid = (state_q == RUN);
        busy           = (state_q == RUN);
        addr_out       = acc_q[NUM_LOOPS-1];
        done           = done_q;
    end

    // Configuration table: writes to the group being walked are dropped.
    always_comb begin
        cfg_d = cfg_q;
        if (cfg_v && !((state_q == RUN) && (cfg_group_id == grp_q))) begin
            cfg_d[cfg_group_id][cfg_loop_id].stride = CFG_STRIDE_W'(cfg_stride);
            cfg_d[cfg_group_id][cfg_loop_id].iter   = CFG_ITER_W'(cfg_iter);
        end
    end

    // Walk datapath. The group's configuration is snapshotted at start so a
    // same-cycle write to that group only affects later walks.
    always_comb begin
        grp_d     = grp_q;
        run_cfg_d = run_cfg_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        step_addr = '0;
        done_d    = beat_fire && last;
`ifdef MEM_WALKER_WRAP_EN
        wrap_base_d = wrap_base_q;
        wrap_size_d = wrap_size_q;
`endif
        if (start_go) begin
            grp_d = start_group_id;
            for (int l = 0; l < NUM_LOOPS; l++) begin
                run_cfg_d[l] = cfg_q[start_group_id][l];
                cnt_d[l]     = '0;
                acc_d[l]     = base_addr;
            end
`ifdef MEM_WALKER_WRAP_EN
            wrap_base_d = wrap_base;
            wrap_size_d = wrap_size;
`endif
        end else if (beat_fire && !last) begin
            for (int l = 0; l < NUM_LOOPS; l++) begin
                if (adv[l]) begin
`ifdef MEM_WALKER_WRAP_EN
                    step_addr = wrap_addr(acc_q[l] + sext_stride(run_cfg_q[l].stride),
                                          run_cfg_q[l].stride[CFG_STRIDE_W-1]);
`else
                    step_addr = acc_q[l] + sext_stride(run_cfg_q[l].stride);
`endif
                end
            end
            // Inner loops restart from the freshly advanced address.
            for (int l = 0; l < NUM_LOOPS; l++) begin
                if (adv[l]) begin
                    cnt_d[l] = cnt_q[l] + ITER_W'(1);
                    acc_d[l] = step_addr;
                end else if (inner_rst[l]) begin
                    cnt_d[l] = '0;
                    acc_d[l] = step_addr;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grp_q  <= '0;
            cnt_q  <= '0;
            acc_q  <= '0;
            done_q <= 1'b0;
            for (int g = 0; g < NUM_GROUPS; g++) begin
                for (int l = 0; l < NUM_LOOPS; l++) begin
                    cfg_q[g][l] <= '0;
                end
            end
            for (int l = 0; l < NUM_LOOPS; l++) begin
                run_cfg_q[l] <= '0;
            end
`ifdef MEM_WALKER_WRAP_EN
            wrap_base_q <= '0;
            wrap_size_q <= '0;
`endif
        end else begin
            grp_q     <= grp_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            done_q    <= done_d;
            cfg_q     <= cfg_d;
            run_cfg_q <= run_cfg_d;
`ifdef MEM_WALKER_WRAP_EN
            wrap_base_q <= wrap_base_d;
            wrap_size_q <= wrap_size_d;
`endif
        end
    end

endmodule
